// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - parametrised UART receiver with parity, framing and break detection
// Optional UART_RX_MAJORITY_EN: 2-of-3 vote of rx_s around each sample point.
module uart_rx_frame #(
    parameter int CLK_DIV   = 434,
    parameter int CNT_W     = 9,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_dat,
    output logic                 rx_vld,
    output logic                 rx_perr,
    output logic                 rx_ferr,
    output logic                 rx_brk,
    output logic                 busy
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_START    = 3'd1;
    localparam logic [2:0] S_DATA     = 3'd2;
    localparam logic [2:0] S_PARITY   = 3'd3;
    localparam logic [2:0] S_STOP     = 3'd4;
    localparam logic [2:0] S_BRK_WAIT = 3'd5;

    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLK_DIV - 1);
`ifdef UART_RX_MAJORITY_EN
    // The vote needs the sample after the nominal point, so every decision lands one clk later.
    localparam logic [CNT_W-1:0] START_DEC = CNT_W'(CLK_DIV / 2);
`else
    localparam logic [CNT_W-1:0] START_DEC = CNT_W'(CLK_DIV / 2 - 1);
`endif
    localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

    logic                 sync1, sync2, sync3;
    logic                 rx_s;
    logic                 fall;
    logic                 bit_s;
    logic [2:0]           state;
    logic [CNT_W-1:0]     cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_acc;
    logic                 all_low;
    logic                 ferr_acc;
    logic                 ferr_next;
    logic                 brk_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            sync3 <= 1'b1;
        end else begin
            sync1 <= rx;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign rx_s = sync2;
    assign fall = sync3 & ~sync2;

`ifdef UART_RX_MAJORITY_EN
    logic hist0, hist1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist0 <= 1'b1;
            hist1 <= 1'b1;
        end else begin
            hist0 <= rx_s;
            hist1 <= hist0;
        end
    end

    assign bit_s = (rx_s & hist0) | (rx_s & hist1) | (hist0 & hist1);
`else
    assign bit_s = rx_s;
`endif

    // Final stop sample folded in combinationally so the flags load with rx_vld.
    assign ferr_next = ferr_acc | ~bit_s;
    assign brk_next  = all_low & ~bit_s;
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_acc  <= 1'b0;
            all_low  <= 1'b0;
            ferr_acc <= 1'b0;
            rx_dat   <= '0;
            rx_vld   <= 1'b0;
            rx_perr  <= 1'b0;
            rx_ferr  <= 1'b0;
            rx_brk   <= 1'b0;
        end else begin
            rx_vld <= 1'b0;
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (fall) begin
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (cnt == START_DEC) begin
                        cnt <= '0;
                        if (bit_s) begin
                            state <= S_IDLE;
                        end else begin
                            state    <= S_DATA;
                            bit_cnt  <= '0;
                            par_acc  <= 1'b0;
                            all_low  <= 1'b1;
                            ferr_acc <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        shreg   <= {bit_s, shreg[DATA_BITS-1:1]};
                        par_acc <= par_acc ^ bit_s;
                        all_low <= all_low & ~bit_s;
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            state   <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        par_acc <= par_acc ^ bit_s;
                        all_low <= all_low & ~bit_s;
                        state   <= S_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt      <= '0;
                        all_low  <= brk_next;
                        ferr_acc <= ferr_next;
                        if (bit_cnt == STOP_LAST) begin
                            // Leave half a bit early so a back-to-back start edge is seen in IDLE.
                            bit_cnt <= '0;
                            rx_vld  <= 1'b1;
                            rx_dat  <= brk_next ? '0 : shreg;
                            rx_perr <= (PARITY != 0) && (par_acc != (PARITY == 1));
                            rx_ferr <= ferr_next;
                            rx_brk  <= brk_next;
                            state   <= ferr_next ? S_BRK_WAIT : S_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_BRK_WAIT: begin
                    cnt <= '0;
                    if (rx_s) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
